btn_conditioner: RTL

- Input-side front end for the stopwatch controller. Converts raw, bouncing, active-low DE10 pushbuttons into clean, synchronous events.
- Per button it produces a debounced level, one-cycle press and release pulses, and a one-cycle long-press pulse.
- It sits between the board pins and the controller's start/stop and lap/reset inputs. The controller consumes pulses only and never sees raw keys.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_channel.sv | 135 +++++++++++++
 rtl/btn_conditioner.sv | 33 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and default cycle counts for the pushbutton front end.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } btn_state_t;

  // 20 ms debounce and 1 s long-press at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_LONG_CYC     = 50_000_000;

endpackage

// File: rtl/btn_channel.sv
// Single pushbutton channel: 2-flop synchroniser, debounce FSM, hold timer and event strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYC + 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYC);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYC);

  btn_state_t       state_q, state_d;
  logic             sync1_q, sync_n_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d, db_inc;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic             long_done_q, long_done_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_pulse_q, long_pulse_d;

  // Both counters saturate so they can never wrap back into range
  assign db_inc   = (db_cnt_q == DbMax) ? db_cnt_q : db_cnt_q + 1'b1;
  assign hold_inc = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_done_d     = long_done_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (!sync_n_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (sync_n_q) begin
          state_d = RELEASED;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DbMax) begin
            state_d       = HELD;
            pressed_d     = 1'b1;
            press_pulse_d = 1'b1;
            hold_cnt_d    = '0;
            long_done_d   = 1'b0;
          end
        end
      end
      HELD: begin
        hold_cnt_d = hold_inc;
        if (hold_inc == HoldMax && !long_done_q) begin
          long_pulse_d = 1'b1;
          long_done_d  = 1'b1;
        end
        if (sync_n_q) begin
          state_d  = DB_REL;
          db_cnt_d = '0;
        end
      end
      DB_REL: begin
        // A bounce back to low resumes the hold timer where it stopped
        if (!sync_n_q) begin
          state_d = HELD;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DbMax) begin
            state_d         = RELEASED;
            pressed_d       = 1'b0;
            release_pulse_d = 1'b1;
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RELEASED;
      sync1_q         <= 1'b1;
      sync_n_q        <= 1'b1;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= btn_n;
      sync_n_q        <= sync1_q;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;

  a_press_on_level : assert property (@(posedge clk) disable iff (reset)
    press_pulse_q |-> pressed_q);
  a_release_on_level : assert property (@(posedge clk) disable iff (reset)
    release_pulse_q |-> !pressed_q);
  a_long_while_held : assert property (@(posedge clk) disable iff (reset)
    long_pulse_q |-> pressed_q);
  a_press_one_cycle : assert property (@(posedge clk) disable iff (reset)
    press_pulse_q |=> !press_pulse_q);

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton front end: one independent debounce channel per raw active-low key.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 2,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_n         (btn_n[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule
